// File: rtl/snoop_bus_pkg.sv
// Shared definitions for the snooping bus: word layout, opcodes, idle word and arbiter states.
// Used by the arbiter, memory model and cache controllers.
package snoop_bus_pkg;

    localparam int WORD_W   = 11;
    localparam int SRC_BIT  = 10;
    localparam int ID_HI    = 9;
    localparam int ID_LO    = 8;
    localparam int RSV_HI   = 7;
    localparam int RSV_LO   = 6;
    localparam int OP_HI    = 5;
    localparam int OP_LO    = 4;
    localparam int ADDR_BIT = 3;
    localparam int DATA_HI  = 2;
    localparam int DATA_LO  = 0;

    localparam logic [1:0] READ_MISS  = 2'b00;
    localparam logic [1:0] WRITE_MISS = 2'b01;
    localparam logic [1:0] INVALIDATE = 2'b10;
    localparam logic [1:0] EMPTY      = 2'b11;

    localparam logic [WORD_W-1:0] IDLE_WORD = 11'b000_0011_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ISSUE    = 2'b01,
        WAIT_MEM = 2'b10,
        RELEASE  = 2'b11
    } state_t;

    // Stamp a controller word as processor-sourced with the owner id and zeroed reserved bits.
    function automatic logic [WORD_W-1:0] make_proc_word(input logic [WORD_W-1:0] word,
                                                         input logic [1:0] id);
        logic [WORD_W-1:0] w;
        w                 = word;
        w[SRC_BIT]        = 1'b1;
        w[ID_HI:ID_LO]    = id;
        w[RSV_HI:RSV_LO]  = 2'b00;
        return w;
    endfunction

    // A memory reply counts only if it targets the current owner and its latched address.
    function automatic logic is_mem_reply(input logic [WORD_W-1:0] mem_word,
                                          input logic [1:0] id,
                                          input logic addr);
        return (mem_word[OP_HI:OP_LO] == EMPTY) && (mem_word[SRC_BIT] == 1'b0) &&
               (mem_word[ID_HI:ID_LO] == id) && (mem_word[ADDR_BIT] == addr);
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker
    import snoop_bus_pkg::*;
#(
    parameter int NUM_PROC = 3
) (
    input  logic [NUM_PROC-1:0] req,
    input  logic [1:0]          pointer,
    output logic [NUM_PROC-1:0] pick,
    output logic [1:0]          pick_idx,
    output logic                any_req
);

    localparam int IW = (NUM_PROC > 2) ? 2 : 1;

    int            idx_s;
    logic [IW-1:0] sel_s;
    logic          hit_s;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        pick     = '0;
        pick_idx = 2'b00;
        any_req  = 1'b0;
        idx_s    = 0;
        sel_s    = '0;
        hit_s    = 1'b0;
        for (int off = 0; off < NUM_PROC; off++) begin
            idx_s         = (int'(pointer) + off) % NUM_PROC;
            sel_s         = IW'(idx_s);
            hit_s         = !any_req && req[sel_s];
            pick[sel_s]   = hit_s;
            pick_idx      = hit_s ? 2'(idx_s) : pick_idx;
            any_req       = any_req | hit_s;
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared snooping bus; serves one
// controller at a time and waits for the memory reply on read misses.
module snoop_bus_arbiter
    import snoop_bus_pkg::*;
#(
    parameter int NUM_PROC = 3,
    parameter int TIMEOUT  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_PROC-1:0]        req,
    input  logic [NUM_PROC*WORD_W-1:0] reqWord,
    input  logic [WORD_W-1:0]          memIn,
    output logic [NUM_PROC-1:0]        grant,
    output logic [WORD_W-1:0]          barramentoOut,
    output logic [NUM_PROC-1:0]        done,
    output logic [2:0]                 respData,
    output logic                       respAddr,
    output logic                       error
);

    localparam int CNT_W = $clog2(TIMEOUT);

    state_t              state_r, state_s;
    logic [1:0]          ptr_r, ptr_s;
    logic [1:0]          owner_r, owner_s;
    logic [1:0]          op_r, op_s;
    logic                addr_r, addr_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [NUM_PROC-1:0] grant_r, grant_s;
    logic [WORD_W-1:0]   bus_r, bus_s;
    logic [NUM_PROC-1:0] done_r, done_s;
    logic [2:0]          resp_data_r, resp_data_s;
    logic                resp_addr_r, resp_addr_s;
    logic                error_r, error_s;

    logic [NUM_PROC-1:0] pick_s;
    logic [1:0]          pick_idx_s;
    logic                any_req_s;
    logic [WORD_W-1:0]   slot_s [NUM_PROC];

    for (genvar i = 0; i < NUM_PROC; i++) begin : g_slot
        assign slot_s[i] = reqWord[i*WORD_W +: WORD_W];
    end

    rr_picker #(.NUM_PROC(NUM_PROC)) u_picker (
        .req      (req),
        .pointer  (ptr_r),
        .pick     (pick_s),
        .pick_idx (pick_idx_s),
        .any_req  (any_req_s)
    );

    // Next-state and next-output logic; done and error default to no pulse.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        owner_s     = owner_r;
        op_s        = op_r;
        addr_s      = addr_r;
        cnt_s       = cnt_r;
        grant_s     = grant_r;
        bus_s       = bus_r;
        done_s      = '0;
        resp_data_s = resp_data_r;
        resp_addr_s = resp_addr_r;
        error_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    owner_s = pick_idx_s;
                    op_s    = slot_s[pick_idx_s][OP_HI:OP_LO];
                    addr_s  = slot_s[pick_idx_s][ADDR_BIT];
                    grant_s = pick_s;
                    bus_s   = make_proc_word(slot_s[pick_idx_s], pick_idx_s);
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                bus_s = IDLE_WORD;
                case (op_r)
                    READ_MISS: begin
                        cnt_s   = '0;
                        state_s = WAIT_MEM;
                    end
                    WRITE_MISS, INVALIDATE, EMPTY: begin
                        done_s  = grant_r;
                        state_s = RELEASE;
                    end
                    default: begin
                        done_s  = grant_r;
                        state_s = RELEASE;
                    end
                endcase
            end
            WAIT_MEM: begin
                if (is_mem_reply(memIn, owner_r, addr_r)) begin
                    resp_data_s = memIn[DATA_HI:DATA_LO];
                    resp_addr_s = memIn[ADDR_BIT];
                    done_s      = grant_r;
                    state_s     = RELEASE;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    resp_data_s = 3'b000;
                    done_s      = grant_r;
                    error_s     = 1'b1;
                    state_s     = RELEASE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            RELEASE: begin
                grant_s = '0;
                state_s = IDLE;
                if (owner_r == 2'(NUM_PROC - 1)) begin
                    ptr_s = 2'b00;
                end else begin
                    ptr_s = owner_r + 2'b01;
                end
            end
            default: begin
                grant_s = '0;
                bus_s   = IDLE_WORD;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset aborts any transaction silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            ptr_r       <= 2'b00;
            owner_r     <= 2'b00;
            op_r        <= EMPTY;
            addr_r      <= 1'b0;
            cnt_r       <= '0;
            grant_r     <= '0;
            bus_r       <= IDLE_WORD;
            done_r      <= '0;
            resp_data_r <= 3'b000;
            resp_addr_r <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            owner_r     <= owner_s;
            op_r        <= op_s;
            addr_r      <= addr_s;
            cnt_r       <= cnt_s;
            grant_r     <= grant_s;
            bus_r       <= bus_s;
            done_r      <= done_s;
            resp_data_r <= resp_data_s;
            resp_addr_r <= resp_addr_s;
            error_r     <= error_s;
        end
    end

    assign grant         = grant_r;
    assign barramentoOut = bus_r;
    assign done          = done_r;
    assign respData      = resp_data_r;
    assign respAddr      = resp_addr_r;
    assign error         = error_r;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: vector table, memory stub and completion scoreboard.
module tb_snoop_bus_arbiter;
    import snoop_bus_pkg::*;

    localparam int NP = 3;
    localparam int TO = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic [NP-1:0]    req;
    logic [NP*11-1:0] reqWord;
    logic [10:0]      memIn;
    logic [NP-1:0]    grant;
    logic [10:0]      barramentoOut;
    logic [NP-1:0]    done;
    logic [2:0]       respData;
    logic             respAddr;
    logic             error;

    snoop_bus_arbiter #(.NUM_PROC(NP), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .req(req), .reqWord(reqWord), .memIn(memIn),
        .grant(grant), .barramentoOut(barramentoOut), .done(done),
        .respData(respData), .respAddr(respAddr), .error(error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] done;
        logic [2:0] data;
        logic       addr;
        logic       err;
        logic       chk_data;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          p;
        logic [10:0] word;
        int          lat;
        bit          silent;
        bit          inj;
        logic [10:0] exp_bus;
        int          exp_lat;
        logic [2:0]  exp_data;
        logic        exp_addr;
        logic        exp_err;
        logic        is_read;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_to(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Memory stub: replies to a read_miss request a configurable number of cycles later.
    logic [3:0]  memoria [2];
    int          mem_lat    = 1;
    bit          mem_silent = 1'b0;
    bit          inject_en  = 1'b0;
    bit          inj_done   = 1'b0;
    int          cd         = 0;
    logic [10:0] reply_word = 11'b000_0011_0000;
    logic [10:0] inject_word = 11'b0_00_00_11_0_111;

    initial begin
        memoria[0] = 4'b1001;
        memoria[1] = 4'b1000;
        forever begin
            @(negedge clock);
            if (reset) begin
                cd = 0;
            end else if (barramentoOut[10] && barramentoOut[5:4] == 2'b00 && !mem_silent) begin
                logic [3:0] m;
                m          = memoria[barramentoOut[3]];
                reply_word = {1'b0, barramentoOut[9:8], 2'b00, 2'b11, barramentoOut[3], m[2:0]};
                cd         = mem_lat;
                inj_done   = 1'b0;
            end
        end
    end

    initial begin
        memIn = 11'b000_0011_0000;
        forever begin
            @(posedge clock);
            #1;
            if (cd == 1) begin
                memIn = reply_word;
            end else if (cd > 1 && inject_en && !inj_done) begin
                memIn    = inject_word;
                inj_done = 1'b1;
            end else begin
                memIn = 11'b000_0011_0000;
            end
            if (cd > 0) cd = cd - 1;
        end
    end

    // Completion monitor: every done pulse is matched against the scoreboard head.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (error && done == '0) begin
                    checks++;
                    errors++;
                    $display("FAIL error_without_done: error=%0b done=%0b", error, done);
                end
                if (done != '0) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=%0b expected none", done);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("done_owner", 32'(done), 32'(e.done));
                        chk("error_flag", 32'(error), 32'(e.err));
                        if (e.chk_data) chk("respData", 32'(respData), 32'(e.data));
                        if (e.chk_data && !e.err) chk("respAddr", 32'(respAddr), 32'(e.addr));
                    end
                end
            end
        end
    end

    task automatic wait_bus_req(output bit ok, input int budget);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            if (barramentoOut[10]) ok = 1'b1;
        end
    endtask

    task automatic wait_done(input int p, output bit ok, input int budget);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (done[p]) ok = 1'b1;
            else @(negedge clock);
        end
    endtask

    task automatic push_exp(input int p, input logic [2:0] data, input logic addr, input logic err,
                            input logic chk_data);
        exp_t e;
        e.done     = 3'(1 << p);
        e.data     = data;
        e.addr     = addr;
        e.err      = err;
        e.chk_data = chk_data;
        sbq.push_back(e);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        bit ok;
        int t0;
        @(negedge clock);
        mem_lat    = v.lat;
        mem_silent = v.silent;
        inject_en  = v.inj;
        push_exp(v.p, v.exp_data, v.exp_addr, v.exp_err, v.is_read);
        reqWord[v.p*11 +: 11] = v.word;
        req[v.p] = 1'b1;
        wait_bus_req(ok, 10);
        if (!ok) begin
            fail_to($sformatf("v%0d_bus_req", n));
            req = '0;
            return;
        end
        t0 = cyc;
        chk($sformatf("v%0d_bus_word", n), 32'(barramentoOut), 32'(v.exp_bus));
        chk($sformatf("v%0d_grant", n), 32'(grant), 32'(1 << v.p));
        @(negedge clock);
        chk($sformatf("v%0d_bus_idle", n), 32'(barramentoOut), 32'(IDLE_WORD));
        wait_done(v.p, ok, 40);
        if (!ok) begin
            fail_to($sformatf("v%0d_done", n));
            req = '0;
            return;
        end
        chk($sformatf("v%0d_latency", n), 32'(cyc - t0), 32'(v.exp_lat));
        req[v.p] = 1'b0;
        @(negedge clock);
        chk($sformatf("v%0d_grant_drop", n), 32'(grant), 32'd0);
    endtask

    initial begin
        bit ok;
        vt[0] = '{p:0, word:11'b00000001000, lat:1, silent:1'b0, inj:1'b0, exp_bus:11'b10000001000,
                  exp_lat:2, exp_data:3'b000, exp_addr:1'b1, exp_err:1'b0, is_read:1'b1};
        vt[1] = '{p:1, word:11'b00000000000, lat:2, silent:1'b0, inj:1'b1, exp_bus:11'b10100000000,
                  exp_lat:3, exp_data:3'b001, exp_addr:1'b0, exp_err:1'b0, is_read:1'b1};
        vt[2] = '{p:2, word:11'b00000101000, lat:1, silent:1'b0, inj:1'b0, exp_bus:11'b11000101000,
                  exp_lat:1, exp_data:3'b000, exp_addr:1'b0, exp_err:1'b0, is_read:1'b0};
        vt[3] = '{p:0, word:11'b01111010101, lat:1, silent:1'b0, inj:1'b0, exp_bus:11'b10000010101,
                  exp_lat:1, exp_data:3'b000, exp_addr:1'b0, exp_err:1'b0, is_read:1'b0};
        vt[4] = '{p:1, word:11'b00000111011, lat:1, silent:1'b0, inj:1'b0, exp_bus:11'b10100111011,
                  exp_lat:1, exp_data:3'b000, exp_addr:1'b0, exp_err:1'b0, is_read:1'b0};
        vt[5] = '{p:0, word:11'b00000001000, lat:1, silent:1'b1, inj:1'b0, exp_bus:11'b10000001000,
                  exp_lat:TO+1, exp_data:3'b000, exp_addr:1'b0, exp_err:1'b1, is_read:1'b1};
        vt[6] = '{p:1, word:11'b00000001110, lat:1, silent:1'b0, inj:1'b0, exp_bus:11'b10100001110,
                  exp_lat:2, exp_data:3'b000, exp_addr:1'b1, exp_err:1'b0, is_read:1'b1};

        reset   = 1'b1;
        req     = '0;
        reqWord = '0;
        repeat (2) @(negedge clock);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_bus", 32'(barramentoOut), 32'(11'b00000110000));
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_error", 32'(error), 32'd0);
        chk("reset_respData", 32'(respData), 32'd0);
        chk("reset_respAddr", 32'(respAddr), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vt[i], i);

        // Round robin with all three requesting constantly.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
        mem_lat    = 1;
        mem_silent = 1'b0;
        inject_en  = 1'b0;
        reqWord    = {11'b00000001000, 11'b00000000000, 11'b00000001000};
        push_exp(0, 3'b000, 1'b1, 1'b0, 1'b1);
        push_exp(1, 3'b001, 1'b0, 1'b0, 1'b1);
        push_exp(2, 3'b000, 1'b1, 1'b0, 1'b1);
        push_exp(0, 3'b000, 1'b1, 1'b0, 1'b1);
        req = 3'b111;
        for (int n = 0; n < 4; n++) begin
            wait_bus_req(ok, 20);
            if (!ok) begin
                fail_to($sformatf("rr%0d_bus_req", n));
                break;
            end
            chk($sformatf("rr%0d_grant", n), 32'(grant), 32'(1 << (n % 3)));
            chk($sformatf("rr%0d_onehot", n), 32'($onehot(grant)), 32'd1);
            chk($sformatf("rr%0d_bus_id", n), 32'(barramentoOut[9:8]), 32'(n % 3));
            @(negedge clock);
            chk($sformatf("rr%0d_bus_idle", n), 32'(barramentoOut), 32'(IDLE_WORD));
            wait_done(n % 3, ok, 20);
            if (!ok) begin
                fail_to($sformatf("rr%0d_done", n));
                break;
            end
            if (n == 3) req = '0;
        end
        req = '0;
        repeat (3) @(negedge clock);
        chk("rr_grant_idle", 32'(grant), 32'd0);

        // Reset in the middle of a read wait, then pointer must be back at 0.
        mem_silent = 1'b1;
        reqWord[0 +: 11] = 11'b00000001000;
        req = 3'b001;
        wait_bus_req(ok, 10);
        if (!ok) fail_to("rst_bus_req");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        req   = '0;
        @(negedge clock);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_bus", 32'(barramentoOut), 32'(IDLE_WORD));
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset      = 1'b0;
        mem_silent = 1'b0;
        reqWord    = {11'b00000001000, 11'b00000000000, 11'b00000001000};
        push_exp(0, 3'b000, 1'b1, 1'b0, 1'b1);
        push_exp(1, 3'b001, 1'b0, 1'b0, 1'b1);
        req = 3'b011;
        wait_bus_req(ok, 10);
        if (!ok) fail_to("post_rst_bus_req");
        chk("post_rst_grant", 32'(grant), 32'b001);
        wait_done(0, ok, 20);
        if (!ok) fail_to("post_rst_done0");
        req[0] = 1'b0;
        @(negedge clock);
        wait_done(1, ok, 20);
        if (!ok) fail_to("post_rst_done1");
        req = '0;

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 11-bit snooping bus between N cache controllers and main memory.
- Grants one requester at a time and drives its request word onto the bus.
- For read_miss, waits for the memory reply, returns the data to the owner, then releases the bus.
- Memory and all snoopers observe the arbiter's bus output.

Parameters:
- NUM_PROC, 3, number of requesters (2..4; bus id field is 2 bits).
- TIMEOUT, 8, WAIT_MEM cycles with no valid reply before abort (>=2).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  NUM_PROC  request per controller; held high until its done pulse
- reqWord  input  NUM_PROC*11  request word per controller; slot i = bits [11i+10:11i]
- memIn  input  11  memory output bus
- grant  output  NUM_PROC  one-hot owner; registered
- barramentoOut  output  11  bus driven to memory and snoopers; registered
- done  output  NUM_PROC  one-cycle pulse to owner when its transaction ends
- respData  output  3  read data; valid with done
- respAddr  output  1  address of the reply; valid with done
- error  output  1  one-cycle pulse on timeout (coincides with done)

Behaviour:
- Bus word fields:
  - [10] source (1 = processor, 0 = memory)
  - [9:8] processor id
  - [7:6] reserved, driven 0
  - [5:4] op: 00 read_miss, 01 write_miss, 10 invalidate, 11 empty
  - [3] address
  - [2:0] data
- IDLE_WORD = 11'b0_00_00_11_0_000 (op = empty). Memory ignores it.
- Reset: state IDLE, rr pointer 0, grant 0, done 0, error 0, respData 0, respAddr 0, barramentoOut = IDLE_WORD. Reset mid-transaction aborts it silently (no done). Requesters reissue.
- IDLE:
  - If any req bit is set, pick the first set bit at or after the pointer, wrapping.
  - Latch the owner's word. Set grant to the owner's bit.
  - barramentoOut <= word with [10]=1, [9:8]=owner index, [7:6]=0. Go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (bus carries the request for exactly one cycle):
  - barramentoOut <= IDLE_WORD.
  - op == read_miss: clear counter, go to WAIT_MEM.
  - op == write_miss or invalidate: pulse done[owner], go to RELEASE.
  - op == empty: pulse done[owner] with no bus effect, go to RELEASE.
- WAIT_MEM:
  - A valid reply is memIn[5:4]==11, memIn[10]==0, memIn[9:8]==owner and memIn[3]==latched address. Other memIn values are ignored.
  - On a valid reply: respData <= memIn[2:0], respAddr <= memIn[3], pulse done[owner], go to RELEASE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no reply: pulse done[owner] and error, respData <= 0, go to RELEASE.
- RELEASE: grant <= 0, pointer <= (owner+1) mod NUM_PROC, go to IDLE.
- Latency, read_miss: req sampled at edge k; bus request visible after edge k; memory replies at edge k+1; done after edge k+2; grant drops after edge k+3; next grant after edge k+4.
- Latency, write_miss/invalidate: done after edge k+1.
- req and reqWord changes are ignored while not in IDLE.
- Simultaneous requests are resolved by the pointer only; there is no fixed priority.

Decomposition:
- Package snoop_bus_pkg holds:
  - op localparams READ_MISS, WRITE_MISS, INVALIDATE, EMPTY
  - field position constants
  - IDLE_WORD
  - state encoding IDLE/ISSUE/WAIT_MEM/RELEASE
  - The memory module and cache controllers also use this package.
- One sub-module, rr_picker: combinational. Inputs req and pointer; outputs one-hot pick, pick index and any_req.

Test Plan:
- P0 read_miss addr 1, memory Memoria[1]=4'b1000 → bus 11'b1_00_00_00_1_000 for one cycle; respData=3'b000, respAddr=1, done[0] two edges after the bus request.
- P1 read_miss addr 0, Memoria[0]=4'b1001 → bus id field 01; respData=3'b001, done[1] only. A memIn reply carrying id 00 injected earlier is ignored.
- req=3'b111 held constantly, all read_miss → grants in order P0, P1, P2, P0. Each grant is one-hot, with at least one IDLE_WORD cycle between successive requests.
- P2 invalidate addr 1 → bus 11'b1_10_00_10_1_000 for one cycle; done[2] next edge; no wait for memory; error=0.
- Memory stubbed silent, P0 read_miss → error and done[0] pulse after TIMEOUT WAIT_MEM cycles; respData=0; bus returns to IDLE_WORD; a subsequent P1 request is served.
- reset asserted during WAIT_MEM → next edge: grant=0, barramentoOut=IDLE_WORD, no done; pointer=0, so P0 wins a following 3'b011 request.
